mandelbrot_scan: RTL and testbench

//  Upstream stage of the Mandelbrot pipeline. Scans one frame in raster order and issues one c = re + j*im
//  per cycle (Q10.22) to the escape pipeline. It carries a valid bit and pixel address through a matching

---
 rtl/mandelbrot_pkg.sv | 22 ++
 rtl/mandelbrot_scan_if.sv | 27 ++
 rtl/tag_delay_line.sv | 41 ++++
 rtl/mandelbrot_scan.sv | 158 +++++++++++++++
 tb/tb_mandelbrot_scan.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot scan front end.
// Holds the Q10.22 fixed-point constants, the scan FSM state type and the
// default frame geometry and pipeline latency. Has no ports.
package mandelbrot_pkg;

   localparam int FRAC_BITS = 22;
   localparam logic [31:0] Q_ONE     = 32'h0040_0000;  // 1.0 in Q10.22
   localparam logic [31:0] ESCAPE_R2 = 32'h0100_0000;  // 4.0 in Q10.22, |z|^2 bailout

   localparam int WIDTH_DEF   = 32;
   localparam int H_RES_DEF   = 640;
   localparam int V_RES_DEF   = 480;
   localparam int LATENCY_DEF = 14;  // 13 iterations + 1 output register
   localparam int ADDR_W_DEF  = 19;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } scan_state_t;

endpackage

// File: rtl/mandelbrot_scan_if.sv
// Bus bundle between the scanner, the escape pipeline and the framebuffer.
//   c_real_out / c_imag_out : point c handed to the escape pipeline
//   overflow_in             : escape flag returned by the pipeline
//   pix_we / pix_addr       : framebuffer write strobe and address
//   pix_inside              : pixel value, 1 = point is in the set
// master = scanner side, slave = pipeline/framebuffer side.
interface mandelbrot_scan_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 19
);
   logic [WIDTH-1:0]  c_real_out;
   logic [WIDTH-1:0]  c_imag_out;
   logic              overflow_in;
   logic              pix_we;
   logic [ADDR_W-1:0] pix_addr;
   logic              pix_inside;

   modport master (
      output c_real_out, c_imag_out, pix_we, pix_addr, pix_inside,
      input  overflow_in
   );

   modport slave (
      input  c_real_out, c_imag_out, pix_we, pix_addr, pix_inside,
      output overflow_in
   );
endinterface

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register that carries a pixel tag {valid, addr} alongside
// the escape pipeline so it pops in the same cycle as the pipeline result.
//   clk   : clock
//   reset : synchronous, active-high; clears the valid bits only
//   din   : {valid, payload} pushed every cycle
//   dout  : {valid, payload} pushed DEPTH cycles earlier
// The payload is not reset; it is meaningless whenever its valid bit is 0.
module tag_delay_line #(
   parameter int DW    = 20,
   parameter int DEPTH = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DEPTH-1:0] vld;
   logic [DW-2:0]    pay [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else begin
         vld[0] <= din[DW-1];
         for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      pay[0] <= din[DW-2:0];
      for (int i = 1; i < DEPTH; i++) begin
         pay[i] <= pay[i-1];
      end
   end

   assign dout = {vld[DEPTH-1], pay[DEPTH-1]};

endmodule

// File: rtl/mandelbrot_scan.sv
// Raster scanner feeding the Mandelbrot escape pipeline.
// Walks one frame in raster order, issuing one point c per cycle (unless
// held), tags each issue with {valid, addr} through a delay line matched to
// the pipeline latency, and turns the returned escape flag into one
// framebuffer write per pixel.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a frame (only looked at in IDLE)
//   hold                : skip issuing this cycle
//   re_min, im_max      : top-left corner of the frame, Q10.22
//   step_re, step_im    : per-pixel real step, per-line imaginary step
//   busy                : frame in progress, until the last write retires
//   frame_done          : one-cycle pulse after the last write
//   bus (master)        : c_*_out / overflow_in / pix_we / pix_addr / pix_inside
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing pixels, one per non-held cycle
// DRAIN | nothing issued; waiting for in-flight tags to retire
module mandelbrot_scan
   import mandelbrot_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int H_RES   = H_RES_DEF,
   parameter int V_RES   = V_RES_DEF,
   parameter int LATENCY = LATENCY_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             hold,
   input  logic [WIDTH-1:0] re_min,
   input  logic [WIDTH-1:0] im_max,
   input  logic [WIDTH-1:0] step_re,
   input  logic [WIDTH-1:0] step_im,
   output logic             busy,
   output logic             frame_done,
   mandelbrot_scan_if.master bus
);

   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int CW = $clog2(LATENCY + 1);

   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

   scan_state_t       state;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  c_real;
   logic [WIDTH-1:0]  c_imag;
   logic [WIDTH-1:0]  re_min_q;
   logic [WIDTH-1:0]  step_re_q;
   logic [WIDTH-1:0]  step_im_q;
   logic [WIDTH-1:0]  c_real_q;
   logic [WIDTH-1:0]  c_imag_q;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_addr;
   logic [CW-1:0]     drain_cnt;
   logic [ADDR_W:0]   tag_out;
   logic              tag_vld;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         addr        <= '0;
         c_real      <= '0;
         c_imag      <= '0;
         re_min_q    <= '0;
         step_re_q   <= '0;
         step_im_q   <= '0;
         c_real_q    <= '0;
         c_imag_q    <= '0;
         issue_valid <= 1'b0;
         issue_addr  <= '0;
         drain_cnt   <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         issue_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  re_min_q  <= re_min;
                  step_re_q <= step_re;
                  step_im_q <= step_im;
                  x         <= '0;
                  y         <= '0;
                  addr      <= '0;
                  c_real    <= re_min;
                  c_imag    <= im_max;
                  busy      <= 1'b1;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (!hold) begin
                  // c and its tag leave together, so the tag enters the
                  // delay line in the same cycle the pipeline sees c.
                  c_real_q    <= c_real;
                  c_imag_q    <= c_imag;
                  issue_valid <= 1'b1;
                  issue_addr  <= addr;
                  addr        <= addr + 1'b1;
                  if (x == X_LAST) begin
                     x      <= '0;
                     y      <= y + 1'b1;
                     c_real <= re_min_q;
                     c_imag <= c_imag - step_im_q;
                     if (y == Y_LAST) begin
                        drain_cnt <= CW'(LATENCY);
                        state     <= DRAIN;
                     end
                  end else begin
                     x      <= x + 1'b1;
                     c_real <= c_real + step_re_q;
                  end
               end
            end
            DRAIN: begin
               // The last tag pops while drain_cnt is 0; finish on that cycle.
               if (drain_cnt == '0) begin
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   tag_delay_line #(
      .DW    (ADDR_W + 1),
      .DEPTH (LATENCY)
   ) u_tags (
      .clk   (clk),
      .reset (reset),
      .din   ({issue_valid, issue_addr}),
      .dout  (tag_out)
   );

   assign tag_vld        = tag_out[ADDR_W];
   assign bus.c_real_out = c_real_q;
   assign bus.c_imag_out = c_imag_q;
   assign bus.pix_we     = tag_vld;
   // Gate with valid so the unreset payload never shows on the bus.
   assign bus.pix_addr   = tag_vld ? tag_out[ADDR_W-1:0] : '0;
   assign bus.pix_inside = tag_vld & ~bus.overflow_in;

endmodule

// File: tb/tb_mandelbrot_scan.sv
module tb_mandelbrot_scan;

   localparam int LAT = 14;
   localparam int HR  = 4;
   localparam int VR  = 2;
   localparam int NPX = HR * VR;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        hold;
   logic [31:0] re_min, im_max, step_re, step_im;
   logic        busy, frame_done;

   mandelbrot_scan_if #(.WIDTH(32), .ADDR_W(19)) bus ();

   mandelbrot_scan #(
      .WIDTH(32), .H_RES(HR), .V_RES(VR), .LATENCY(LAT), .ADDR_W(19)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .hold       (hold),
      .re_min     (re_min),
      .im_max     (im_max),
      .step_re    (step_re),
      .step_im    (step_im),
      .busy       (busy),
      .frame_done (frame_done),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Escape pipeline model: 13 iterations of z = z^2 + c in Q10.22, bail out at |z|^2 > 4.
   function automatic bit escapes(input logic [31:0] cr, input logic [31:0] ci);
      int zr = 0;
      int zi = 0;
      longint rr, ii, ri;
      for (int k = 0; k < 13; k++) begin
         rr = (longint'(zr) * longint'(zr)) >>> 22;
         ii = (longint'(zi) * longint'(zi)) >>> 22;
         ri = (longint'(zr) * longint'(zi)) >>> 21;
         zr = int'(rr - ii + longint'($signed(cr)));
         zi = int'(ri + longint'($signed(ci)));
         if (((longint'(zr) * longint'(zr)) >>> 22) + ((longint'(zi) * longint'(zi)) >>> 22)
             > 64'sh100_0000) return 1'b1;
      end
      return 1'b0;
   endfunction

   // History of presented c values and their escape flags, newest at index 0.
   logic [31:0] hr [LAT];
   logic [31:0] hi [LAT];
   bit          hf [LAT];
   initial for (int k = 0; k < LAT; k++) begin hr[k] = '0; hi[k] = '0; hf[k] = 1'b0; end

   always @(posedge clk) begin
      #1 bus.overflow_in = hf[LAT-1];
   end

   int          wq_addr [$];
   bit          wq_in   [$];
   logic [31:0] wq_cr   [$];
   logic [31:0] wq_ci   [$];
   int          wq_cyc  [$];
   int          fd_cnt = 0;
   int          fd_cyc = 0;
   bit          fd_busy = 1'b0;

   always @(negedge clk) begin
      if (bus.pix_we) begin
         wq_addr.push_back(int'(bus.pix_addr));
         wq_in.push_back(bus.pix_inside);
         wq_cr.push_back(hr[LAT-1]);
         wq_ci.push_back(hi[LAT-1]);
         wq_cyc.push_back(cyc);
      end
      if (frame_done) begin
         fd_cnt++;
         fd_cyc  = cyc;
         fd_busy = busy;
      end
      for (int k = LAT - 1; k > 0; k--) begin
         hr[k] = hr[k-1]; hi[k] = hi[k-1]; hf[k] = hf[k-1];
      end
      hr[0] = bus.c_real_out;
      hi[0] = bus.c_imag_out;
      hf[0] = escapes(bus.c_real_out, bus.c_imag_out);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wq_addr.delete(); wq_in.delete(); wq_cr.delete(); wq_ci.delete(); wq_cyc.delete();
   endtask

   typedef struct {
      logic [31:0] re_min;
      logic [31:0] im_max;
      logic [31:0] step_re;
      logic [31:0] step_im;
      int          hold_mode;   // 0 none, 1 every other cycle, 2 two of three
      logic [7:0]  exp_inside;  // bit a = pixel a inside the set
      logic [31:0] exp_cr0;     // c_real of pixel 0
      logic [31:0] exp_ci1;     // c_imag of line 1
   } vec_t;

   vec_t vecs [4];

   function automatic bit hold_pat(input int mode, input int n);
      case (mode)
         1:       return n[0];
         2:       return (n % 3) != 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic apply_params(input vec_t v);
      re_min = v.re_min; im_max = v.im_max; step_re = v.step_re; step_im = v.step_im;
   endtask

   // Checks common to every completed frame: write count, order, c alignment, pixel values, end timing.
   task automatic check_frame(input vec_t v, input int fd0, input string tag);
      logic [31:0] ecr, eci;
      check({tag, " frame_done_count"}, 64'(fd_cnt - fd0), 64'd1);
      check({tag, " write_count"}, 64'(wq_addr.size()), 64'(NPX));
      for (int i = 0; i < wq_addr.size() && i < NPX; i++) begin
         ecr = v.re_min + 32'(i % HR) * v.step_re;
         eci = v.im_max - 32'(i / HR) * v.step_im;
         check($sformatf("%s addr[%0d]", tag, i), 64'(wq_addr[i]), 64'(i));
         check($sformatf("%s c_real[%0d]", tag, i), 64'(wq_cr[i]), 64'(ecr));
         check($sformatf("%s c_imag[%0d]", tag, i), 64'(wq_ci[i]), 64'(eci));
         check($sformatf("%s inside[%0d]", tag, i), 64'(wq_in[i]), 64'(v.exp_inside[i]));
      end
      if (wq_addr.size() > 4) begin
         check({tag, " c_real_first"}, 64'(wq_cr[0]), 64'(v.exp_cr0));
         check({tag, " c_imag_line1"}, 64'(wq_ci[4]), 64'(v.exp_ci1));
         check({tag, " done_after_last_write"}, 64'(fd_cyc - wq_cyc[$]), 64'd1);
      end
      check({tag, " busy_at_done"}, 64'(fd_busy), 64'd0);
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int fd0;
      int scyc;
      clear_log();
      fd0 = fd_cnt;
      apply_params(v);
      start = 1'b1;
      tick();
      start = 1'b0;
      scyc = cyc;
      check({tag, " busy_after_start"}, 64'(busy), 64'd1);
      for (int n = 0; n < 300; n++) begin
         if (fd_cnt != fd0) break;
         hold = hold_pat(v.hold_mode, n);
         tick();
      end
      hold = 1'b0;
      check_frame(v, fd0, tag);
      if (v.hold_mode == 0 && wq_cyc.size() > 0)
         check({tag, " first_write_latency"}, 64'(wq_cyc[0] - scyc), 64'(LAT + 1));
   endtask

   initial begin
      int fd0;
      // re_min     im_max       step_re      step_im      hold inside  cr0          ci1
      vecs[0] = '{32'hFF80_0000, 32'h0000_0000, 32'h0040_0000, 32'h0040_0000, 0, 8'h47, 32'hFF80_0000, 32'hFFC0_0000};
      vecs[1] = '{32'hFF80_0000, 32'h0040_0000, 32'h0040_0000, 32'h0020_0000, 0, 8'h44, 32'hFF80_0000, 32'h0020_0000};
      vecs[2] = '{32'hFF80_0000, 32'h0000_0000, 32'h0040_0000, 32'h0040_0000, 1, 8'h47, 32'hFF80_0000, 32'hFFC0_0000};
      vecs[3] = '{32'h7F80_0000, 32'h0000_0000, 32'h0040_0000, 32'h0040_0000, 2, 8'h00, 32'h7F80_0000, 32'hFFC0_0000};

      reset = 1'b1; start = 1'b0; hold = 1'b0;
      apply_params(vecs[0]);
      repeat (3) tick();
      reset = 1'b0;
      check("rst busy",       64'(busy),           64'd0);
      check("rst frame_done", 64'(frame_done),     64'd0);
      check("rst pix_we",     64'(bus.pix_we),     64'd0);
      check("rst pix_addr",   64'(bus.pix_addr),   64'd0);
      check("rst pix_inside", 64'(bus.pix_inside), 64'd0);
      check("rst c_real_out", 64'(bus.c_real_out), 64'd0);
      check("rst c_imag_out", 64'(bus.c_imag_out), 64'd0);
      repeat (2) tick();

      for (int v = 0; v < 4; v++) begin
         run_frame(vecs[v], $sformatf("vec%0d", v));
         repeat (3) tick();
      end

      // Reset a few cycles into SCAN: nothing may be written afterwards.
      clear_log();
      fd0 = fd_cnt;
      apply_params(vecs[0]);
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check("midrst busy",   64'(busy),       64'd0);
      check("midrst pix_we", 64'(bus.pix_we), 64'd0);
      repeat (30) tick();
      check("midrst writes",     64'(wq_addr.size()), 64'd0);
      check("midrst frame_done", 64'(fd_cnt - fd0),   64'd0);
      run_frame(vecs[0], "after_rst");
      repeat (3) tick();

      // start pulses while busy (once in SCAN, once in DRAIN) must be ignored.
      clear_log();
      fd0 = fd_cnt;
      apply_params(vecs[0]);
      start = 1'b1; tick(); start = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (fd_cnt != fd0) break;
         start = (n == 4) || (n == 12);
         tick();
      end
      start = 1'b0;
      check_frame(vecs[0], fd0, "start_busy");
      repeat (40) tick();
      check("start_busy extra frames", 64'(fd_cnt - fd0), 64'd1);
      check("start_busy idle busy",    64'(busy),         64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
